// File: rtl/umi_reghost.sv
// umi_reghost: single-outstanding UMI initiator. Turns local register accesses into
// UMI requests, waits for the matching response (or a timeout) and reports completion.
module umi_reghost #(
    parameter int              RW       = 32,
    parameter int              CW       = 32,
    parameter int              AW       = 64,
    parameter int              DW       = 64,
    parameter logic [AW-1:0]   HOSTADDR = '0,
    parameter logic [4:0]      HOSTID   = 5'd0,
    parameter int              TIMEOUT  = 1024
) (
    input  logic               clk,
    input  logic               reset,
    // local register port
    input  logic               reg_valid,
    input  logic               reg_write,
    input  logic               reg_posted,
    input  logic [AW-1:0]      reg_addr,
    input  logic [RW-1:0]      reg_wdata,
    output logic               reg_ready,
    output logic               reg_rvalid,
    output logic [RW-1:0]      reg_rdata,
    output logic [1:0]         reg_err,
    output logic               resp_unexpected,
    // UMI request channel
    output logic               uhost_req_valid,
    output logic [CW-1:0]      uhost_req_cmd,
    output logic [AW-1:0]      uhost_req_dstaddr,
    output logic [AW-1:0]      uhost_req_srcaddr,
    output logic [DW-1:0]      uhost_req_data,
    input  logic               uhost_req_ready,
    // UMI response channel
    input  logic               uhost_resp_valid,
    input  logic [CW-1:0]      uhost_resp_cmd,
    input  logic [AW-1:0]      uhost_resp_dstaddr,
    input  logic [AW-1:0]      uhost_resp_srcaddr,
    input  logic [DW-1:0]      uhost_resp_data,
    output logic               uhost_resp_ready
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } state_t;

    localparam logic [4:0]  OP_READ   = 5'h01;
    localparam logic [4:0]  OP_WRITE  = 5'h03;
    localparam logic [4:0]  OP_POSTED = 5'h05;
    localparam logic [4:0]  OP_RDRESP = 5'h02;
    localparam logic [4:0]  OP_WRRESP = 5'h04;
    localparam logic [2:0]  SIZE      = 3'($clog2(RW / 8));
    localparam logic [16:0] TMO       = 17'(TIMEOUT);

    state_t        state;
    state_t        state_next;
    logic          running;
    logic          write_q;
    logic          posted_q;
    logic [AW-1:0] addr_q;
    logic [RW-1:0] wdata_q;
    logic [15:0]   timer;
    logic          accept;
    logic          req_fire;
    logic          resp_fire;
    logic          resp_match;
    logic          expire;
    logic [CW-1:0] cmd_int;
    logic [DW-1:0] data_int;
    logic          unused_bits;

    assign accept     = (state == IDLE) && running && reg_valid;
    assign req_fire   = (state == REQ) && uhost_req_ready;
    assign resp_fire  = uhost_resp_valid && running;
    assign resp_match = (state == RESP) && uhost_resp_valid
                        && (uhost_resp_dstaddr == HOSTADDR)
                        && (uhost_resp_cmd[4:0] == (write_q ? OP_WRRESP : OP_RDRESP));
    // The wait ends on the edge where the timer would reach TIMEOUT-1.
    assign expire     = (TIMEOUT != 0) && (state == RESP)
                        && (({1'b0, timer} + 17'd2) >= TMO);

    assign unused_bits = ^{uhost_resp_srcaddr, uhost_resp_cmd, uhost_resp_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = REQ;
            REQ:     if (uhost_req_ready) state_next = posted_q ? DONE : RESP;
            RESP:    if (resp_match || expire) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request fields are only driven while the request is presented.
    always_comb begin
        cmd_int  = '0;
        data_int = '0;
        if (state == REQ) begin
            cmd_int[4:0]   = !write_q ? OP_READ : (posted_q ? OP_POSTED : OP_WRITE);
            cmd_int[7:5]   = SIZE;
            cmd_int[22]    = 1'b1;
            cmd_int[31:27] = HOSTID;
            if (write_q) begin
                data_int[RW-1:0] = wdata_q;
            end
        end
    end

    assign uhost_req_valid   = (state == REQ);
    assign uhost_req_cmd     = cmd_int;
    assign uhost_req_data    = data_int;
    assign uhost_req_dstaddr = (state == REQ) ? addr_q : '0;
    assign uhost_req_srcaddr = (state == REQ) ? HOSTADDR : '0;
    assign uhost_resp_ready  = running;
    assign reg_ready         = (state == IDLE) && running;
    assign reg_rvalid        = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            running         <= 1'b0;
            write_q         <= 1'b0;
            posted_q        <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            timer           <= '0;
            reg_rdata       <= '0;
            reg_err         <= 2'b00;
            resp_unexpected <= 1'b0;
        end else begin
            running         <= 1'b1;
            resp_unexpected <= resp_fire && !resp_match;
            if (accept) begin
                write_q  <= reg_write;
                posted_q <= reg_write && reg_posted;
                addr_q   <= reg_addr;
                wdata_q  <= reg_wdata;
            end
            if (req_fire) begin
                timer <= '0;
            end else if (state == RESP) begin
                timer <= timer + 16'd1;
            end
            // A response arriving on the timeout edge takes priority.
            if (req_fire && posted_q) begin
                reg_rdata <= '0;
                reg_err   <= 2'b00;
            end else if (resp_match) begin
                reg_err   <= uhost_resp_cmd[26:25];
                reg_rdata <= write_q ? '0 : uhost_resp_data[RW-1:0];
            end else if (expire) begin
                reg_err   <= 2'b11;
                reg_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_umi_reghost.sv
// tb_umi_reghost: randomized scoreboard bench for umi_reghost with a memory-backed
// register device model; monitors check requests, completions and dropped responses.
module tb_umi_reghost;

    localparam int          RW       = 32;
    localparam int          CW       = 32;
    localparam int          AW       = 64;
    localparam int          DW       = 64;
    localparam int          TIMEOUT  = 16;
    localparam logic [63:0] HOSTADDR = 64'h0000_0000_0000_1000;
    localparam logic [4:0]  HOSTID   = 5'h0B;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          reg_valid, reg_write, reg_posted;
    logic [AW-1:0] reg_addr;
    logic [RW-1:0] reg_wdata;
    logic          reg_ready, reg_rvalid, resp_unexpected;
    logic [RW-1:0] reg_rdata;
    logic [1:0]    reg_err;
    logic          uhost_req_valid, uhost_req_ready;
    logic [CW-1:0] uhost_req_cmd;
    logic [AW-1:0] uhost_req_dstaddr, uhost_req_srcaddr;
    logic [DW-1:0] uhost_req_data;
    logic          uhost_resp_valid, uhost_resp_ready;
    logic [CW-1:0] uhost_resp_cmd;
    logic [AW-1:0] uhost_resp_dstaddr, uhost_resp_srcaddr;
    logic [DW-1:0] uhost_resp_data;

    typedef struct {
        logic [31:0] cmd;
        logic [63:0] dst;
        logic [63:0] src;
        logic [63:0] data;
    } reqExp_t;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
        int          cyc;
    } cplExp_t;

    reqExp_t     expReq[$];
    cplExp_t     expCpl[$];
    cplExp_t     curCpl;
    logic [31:0] mem [logic [63:0]];
    int          expDrops = 0;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    umi_reghost #(
        .RW(RW), .CW(CW), .AW(AW), .DW(DW),
        .HOSTADDR(HOSTADDR), .HOSTID(HOSTID), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .reg_valid(reg_valid), .reg_write(reg_write), .reg_posted(reg_posted),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_ready(reg_ready),
        .reg_rvalid(reg_rvalid), .reg_rdata(reg_rdata), .reg_err(reg_err),
        .resp_unexpected(resp_unexpected),
        .uhost_req_valid(uhost_req_valid), .uhost_req_cmd(uhost_req_cmd),
        .uhost_req_dstaddr(uhost_req_dstaddr), .uhost_req_srcaddr(uhost_req_srcaddr),
        .uhost_req_data(uhost_req_data), .uhost_req_ready(uhost_req_ready),
        .uhost_resp_valid(uhost_resp_valid), .uhost_resp_cmd(uhost_resp_cmd),
        .uhost_resp_dstaddr(uhost_resp_dstaddr), .uhost_resp_srcaddr(uhost_resp_srcaddr),
        .uhost_resp_data(uhost_resp_data), .uhost_resp_ready(uhost_resp_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    task automatic failNote(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s actual=expired required=event", name);
    endtask

    // Request command as the UMI rules define it for this host.
    function automatic logic [31:0] expCmd(input int kind);
        logic [31:0] c;
        c = 32'(HOSTID) << 27;
        c = c | (32'd1 << 22) | (32'($clog2(RW / 8)) << 5);
        c = c | ((kind == 0) ? 32'h01 : (kind == 1) ? 32'h03 : 32'h05);
        return c;
    endfunction

    function automatic logic [31:0] readModel(input logic [63:0] addr);
        if (mem.exists(addr)) return mem[addr];
        return addr[31:0] ^ 32'h5A5A_0000;
    endfunction

    // Monitor samples mid-low-phase, seeing exactly what the next rising edge samples.
    always begin
        @(negedge clk);
        #2;
        if (!reset) begin
            if (uhost_req_valid) begin
                if (expReq.size() == 0) begin
                    failNote("req_spurious");
                end else begin
                    checkOutput("req_cmd", 64'(uhost_req_cmd), 64'(expReq[0].cmd));
                    checkOutput("req_dstaddr", uhost_req_dstaddr, expReq[0].dst);
                    checkOutput("req_srcaddr", uhost_req_srcaddr, expReq[0].src);
                    checkOutput("req_data", uhost_req_data, expReq[0].data);
                    if (uhost_req_ready) void'(expReq.pop_front());
                end
            end
            if (reg_rvalid) begin
                if (expCpl.size() == 0) begin
                    failNote("rvalid_spurious");
                end else begin
                    curCpl = expCpl.pop_front();
                    checkOutput("cpl_rdata", 64'(reg_rdata), 64'(curCpl.rdata));
                    checkOutput("cpl_err", 64'(reg_err), 64'(curCpl.err));
                    checkOutput("cpl_cycle", 64'(cyc), 64'(curCpl.cyc));
                end
            end
            if (resp_unexpected) begin
                checkOutput("drop_pulse", 64'(expDrops > 0), 64'd1);
                if (expDrops > 0) expDrops--;
            end
        end
    end

    task automatic waitIdle(output bit ok);
        int n;
        n  = 0;
        ok = 1'b1;
        @(negedge clk);
        while (!reg_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!reg_ready) begin
            failNote("ready_wait");
            ok = 1'b0;
        end
    endtask

    task automatic waitCpl();
        int n;
        n = 0;
        while (expCpl.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (expCpl.size() != 0) begin
            failNote("cpl_wait");
            expCpl.delete();
        end
    endtask

    task automatic sendResp(input logic [4:0] op, input logic [63:0] dst, input logic [1:0] err,
                            input logic [31:0] data);
        uhost_resp_valid   = 1'b1;
        uhost_resp_cmd     = (32'(err) << 25) | 32'(op) | ($urandom & 32'h01FF_FFE0);
        uhost_resp_dstaddr = dst;
        uhost_resp_srcaddr = {$urandom, $urandom};
        uhost_resp_data    = {$urandom, data};
        @(negedge clk);
        uhost_resp_valid   = 1'b0;
        uhost_resp_cmd     = $urandom;
        uhost_resp_dstaddr = {$urandom, $urandom};
        uhost_resp_data    = {$urandom, $urandom};
    endtask

    // kind: 0 read, 1 write, 2 posted. mode: 0 normal, 1 no response (timeout),
    // 2 wrong dstaddr first, 3 wrong opcode first, 4 response on the timeout edge.
    task automatic applyStimulus(input int kind, input logic [63:0] addr, input logic [31:0] wdata,
                                 input int readyDelay, input int respDelay, input logic [1:0] err,
                                 input int mode);
        bit          ok;
        int          hs;
        logic [31:0] value;
        logic [31:0] devData;
        logic [4:0]  respOp;
        waitIdle(ok);
        if (!ok) return;
        reg_valid  = 1'b1;
        reg_write  = (kind != 0);
        reg_posted = (kind == 2);
        reg_addr   = addr;
        reg_wdata  = wdata;
        expReq.push_back('{expCmd(kind), addr, HOSTADDR, (kind == 0) ? 64'd0 : {32'd0, wdata}});
        @(negedge clk);
        reg_valid  = 1'b0;
        reg_write  = 1'($urandom);
        reg_posted = 1'($urandom);
        reg_addr   = {$urandom, $urandom};
        reg_wdata  = $urandom;
        repeat (readyDelay) @(negedge clk);
        uhost_req_ready = 1'b1;
        hs = cyc + 1;
        if (kind != 0) mem[addr] = wdata;
        if (kind == 2) expCpl.push_back('{32'd0, 2'b00, hs});
        @(negedge clk);
        uhost_req_ready = 1'b0;
        if (kind != 2) begin
            value   = (kind == 0) ? readModel(addr) : 32'd0;
            devData = (kind == 0) ? value : $urandom;
            respOp  = (kind == 0) ? 5'h02 : 5'h04;
            case (mode)
                1: begin
                    expCpl.push_back('{32'd0, 2'b11, hs + TIMEOUT - 1});
                    waitCpl();
                    repeat (2) @(negedge clk);
                    expDrops++;
                    sendResp(respOp, HOSTADDR, err, devData);
                end
                2, 3: begin
                    expDrops++;
                    if (mode == 2) sendResp(respOp, HOSTADDR ^ 64'h40, err, devData);
                    else sendResp((kind == 0) ? 5'h04 : 5'h02, HOSTADDR, err, devData);
                    repeat (respDelay) @(negedge clk);
                    expCpl.push_back('{value, err, cyc + 1});
                    sendResp(respOp, HOSTADDR, err, devData);
                end
                4: begin
                    repeat (TIMEOUT - 2) @(negedge clk);
                    expCpl.push_back('{value, err, cyc + 1});
                    sendResp(respOp, HOSTADDR, err, devData);
                end
                default: begin
                    repeat (respDelay) @(negedge clk);
                    expCpl.push_back('{value, err, cyc + 1});
                    sendResp(respOp, HOSTADDR, err, devData);
                end
            endcase
        end
        waitCpl();
    endtask

    initial begin
        bit          ok;
        int          r;
        int          md;
        logic [63:0] a;
        reg_valid = 0; reg_write = 0; reg_posted = 0; reg_addr = '0; reg_wdata = '0;
        uhost_req_ready = 0; uhost_resp_valid = 0; uhost_resp_cmd = '0;
        uhost_resp_dstaddr = '0; uhost_resp_srcaddr = '0; uhost_resp_data = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        checkOutput("rst_reg_ready", 64'(reg_ready), 64'd0);
        checkOutput("rst_rvalid", 64'(reg_rvalid), 64'd0);
        checkOutput("rst_rdata", 64'(reg_rdata), 64'd0);
        checkOutput("rst_err", 64'(reg_err), 64'd0);
        checkOutput("rst_unexpected", 64'(resp_unexpected), 64'd0);
        checkOutput("rst_req_valid", 64'(uhost_req_valid), 64'd0);
        checkOutput("rst_req_cmd", 64'(uhost_req_cmd), 64'd0);
        checkOutput("rst_resp_ready", 64'(uhost_resp_ready), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("run_reg_ready", 64'(reg_ready), 64'd1);
        checkOutput("run_resp_ready", 64'(uhost_resp_ready), 64'd1);

        $display("[TB] directed accesses");
        mem[64'h20] = 32'hDEADBEEF;
        applyStimulus(0, 64'h20, 32'h0, 0, 4, 2'b00, 0);
        applyStimulus(1, 64'h8, 32'h1234, 1, 2, 2'b10, 0);
        applyStimulus(2, 64'h30, 32'hCAFE_0001, 5, 0, 2'b00, 0);
        applyStimulus(0, 64'h8, 32'h0, 0, 0, 2'b01, 0);
        applyStimulus(0, 64'h40, 32'h0, 0, 0, 2'b00, 1);
        applyStimulus(0, 64'h30, 32'h0, 0, 3, 2'b00, 2);
        applyStimulus(1, 64'h48, 32'h55, 2, 1, 2'b11, 3);
        applyStimulus(0, 64'h20, 32'h0, 0, 0, 2'b00, 4);

        $display("[TB] reset during request");
        waitIdle(ok);
        if (ok) begin
            reg_valid = 1'b1; reg_write = 1'b0; reg_posted = 1'b0; reg_addr = 64'h60;
            expReq.push_back('{expCmd(0), 64'h60, HOSTADDR, 64'd0});
            @(negedge clk);
            reg_valid = 1'b0;
            @(negedge clk);
            checkOutput("req_valid_pre_reset", 64'(uhost_req_valid), 64'd1);
            #3 reset = 1'b1;
            #1;
            checkOutput("req_valid_in_reset", 64'(uhost_req_valid), 64'd0);
            checkOutput("ready_in_reset", 64'(reg_ready), 64'd0);
            expReq.delete();
            repeat (2) @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            checkOutput("ready_post_reset", 64'(reg_ready), 64'd1);
            checkOutput("rdata_post_reset", 64'(reg_rdata), 64'd0);
            checkOutput("req_valid_post_reset", 64'(uhost_req_valid), 64'd0);
        end

        $display("[TB] random accesses");
        for (int i = 0; i < 40; i++) begin
            a  = 64'($urandom_range(0, 15)) << 3;
            r  = $urandom_range(0, 9);
            md = (r <= 5) ? 0 : r - 5;
            applyStimulus($urandom_range(0, 2), a, $urandom, $urandom_range(0, 3),
                          $urandom_range(0, 8), 2'($urandom), md);
        end

        repeat (5) @(negedge clk);
        checkOutput("drops_pending", 64'(expDrops), 64'd0);
        checkOutput("req_queue_left", 64'(expReq.size()), 64'd0);
        checkOutput("cpl_queue_left", 64'(expCpl.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        bad++;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
